// File: rtl/pixel_consumer.sv
// pixel_consumer: takes an unthrottled pixel stream, tags each pixel with
// start-of-frame / end-of-line / end-of-frame, buffers it in a small skid
// FIFO for a ready/valid downstream, and keeps per-frame sum and count.
module pixel_consumer #(
    parameter int IMAGE_SIZE  = 1024,
    parameter int IMAGE_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        sensor_clk,
    input  logic        rst_n,
    input  logic [7:0]  pixel,
    input  logic        valid,
    output logic        ready,
    output logic [7:0]  out_pixel,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_count,
    output logic        overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int IDX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IMAGE_SIZE - 1);

    // FIFO storage and bookkeeping
    logic [10:0]      mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             run_reg;

    // Frame position and accumulation
    logic [COL_W-1:0] col_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [15:0]      run_sum_reg;
    logic [15:0]      frame_sum_reg;
    logic [15:0]      frame_count_reg;
    logic             frame_done_reg;
    logic             overflow_reg;

    logic        sof_in;
    logic        eol_in;
    logic        eof_in;
    logic [15:0] sum_next;
    logic        fifo_full;
    logic        fifo_pop;
    logic        fifo_wr;
    logic        beat_drop;
    logic [CNT_W-1:0] free_cnt;
    logic [10:0] head_entry;

    assign sof_in   = (idx_reg == '0);
    assign eol_in   = (col_reg == COL_LAST);
    assign eof_in   = (idx_reg == IDX_LAST);
    assign sum_next = sof_in ? {8'h00, pixel} : (run_sum_reg + {8'h00, pixel});

    assign fifo_full = (count_reg == DEPTH_C);
    assign out_valid = (count_reg != '0);
    assign fifo_pop  = out_valid && out_ready;
    // A full FIFO still accepts a beat when the head leaves on the same edge.
    assign fifo_wr   = valid && (!fifo_full || fifo_pop);
    assign beat_drop = valid && fifo_full && !fifo_pop;

    // The producer reacts one cycle late, so keep room for the beat in flight.
    assign free_cnt = DEPTH_C - count_reg;
    assign ready    = run_reg && (free_cnt >= CNT_W'(2));

    // Head is shown combinationally; an empty FIFO (including reset) reads 0.
    assign head_entry = mem_reg[rd_ptr_reg];
    assign {out_sof, out_eol, out_eof, out_pixel} = out_valid ? head_entry : 11'h000;

    assign frame_done  = frame_done_reg;
    assign frame_sum   = frame_sum_reg;
    assign frame_count = frame_count_reg;
    assign overflow    = overflow_reg;

    // Entry storage: written in arrival order, contents need no reset.
    always_ff @(posedge sensor_clk) begin
        if (fifo_wr) begin
            mem_reg[wr_ptr_reg] <= {sof_in, eol_in, eof_in, pixel};
        end
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            run_reg    <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (fifo_wr && !fifo_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!fifo_wr && fifo_pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Frame position, running sum and frame statistics advance on every beat, dropped or not.
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg         <= '0;
            idx_reg         <= '0;
            run_sum_reg     <= '0;
            frame_sum_reg   <= '0;
            frame_count_reg <= '0;
            frame_done_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (valid) begin
                col_reg     <= eol_in ? '0 : (col_reg + COL_W'(1));
                idx_reg     <= eof_in ? '0 : (idx_reg + IDX_W'(1));
                run_sum_reg <= sum_next;
                if (eof_in) begin
                    frame_sum_reg   <= sum_next;
                    frame_done_reg  <= 1'b1;
                    frame_count_reg <= frame_count_reg + 16'd1;
                end
                if (beat_drop) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_consumer.sv
// Directed bench for pixel_consumer: a vector table for the overflow and
// full-with-pop corners, then hand-written streaming, back-pressure and
// mid-frame reset sequences.
module tb_pixel_consumer;

    logic        sensor_clk;
    logic        rst_n;
    logic [7:0]  pixel;
    logic        valid;
    logic        ready;
    logic [7:0]  out_pixel;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [15:0] frame_count;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    pixel_consumer #(
        .IMAGE_SIZE (1024),
        .IMAGE_WIDTH(32),
        .FIFO_DEPTH (4)
    ) dut (
        .sensor_clk (sensor_clk),
        .rst_n      (rst_n),
        .pixel      (pixel),
        .valid      (valid),
        .ready      (ready),
        .out_pixel  (out_pixel),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .frame_count(frame_count),
        .overflow   (overflow)
    );

    initial sensor_clk = 1'b0;
    always #5 sensor_clk = ~sensor_clk;

    typedef struct {
        logic        valid;
        logic [7:0]  pixel;
        logic        out_ready;
        logic        exp_ready;
        logic        exp_out_valid;
        logic [10:0] exp_head;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [12];

    task automatic step();
        @(posedge sensor_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        valid     = 1'b0;
        pixel     = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [10:0] head();
        return {out_sof, out_eol, out_eof, out_pixel};
    endfunction

    logic [10:0] exp_q [$];
    logic [10:0] e;
    logic        rdy_prev;
    int          sent;
    int          pushed;
    int          done_n;
    int          done_cyc;
    int          last_cyc;

    initial begin
        // rows: valid, pixel, out_ready, exp ready, exp out_valid, exp head {sof,eol,eof,pixel}, exp overflow
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 11'h411, 1'b0};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 11'h411, 1'b0};
        tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 11'h411, 1'b0};
        tbl[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 11'h411, 1'b0};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 11'h411, 1'b1};
        tbl[6]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 11'h411, 1'b1};
        tbl[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 11'h022, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 11'h033, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 11'h044, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 11'h077, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 11'h000, 1'b1};

        // Reset state
        rst_n     = 1'b0;
        valid     = 1'b0;
        pixel     = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_ready", ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_head", head(), 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_sum", frame_sum, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_run", ready, 0);

        // Table: fill, forced overflow, push into full FIFO with pop, drain
        for (int i = 0; i < 12; i++) begin
            valid     = tbl[i].valid;
            pixel     = tbl[i].pixel;
            out_ready = tbl[i].out_ready;
            step();
            $display("vec %0d: ready=%0b out_valid=%0b head=0x%03h overflow=%0b",
                     i, ready, out_valid, head(), overflow);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_out_valid);
            chk($sformatf("tbl%0d_head", i), head(), tbl[i].exp_head);
            chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].exp_ovf);
        end

        // Dropped beats still advanced the index: next beat is idx 7, eol lands on idx 31
        for (int k = 7; k <= 32; k++) begin
            valid     = 1'b1;
            pixel     = 8'(k);
            out_ready = 1'b0;
            step();
            e = {1'b0, (k == 31), 1'b0, 8'(k)};
            chk($sformatf("idx%0d_head", k), head(), e);
            valid     = 1'b0;
            out_ready = 1'b1;
            step();
            chk($sformatf("idx%0d_popped", k), out_valid, 0);
        end
        chk("overflow_sticky", overflow, 1);

        // Streaming a full frame of idx[7:0] with a one-cycle-latency producer
        do_reset();
        out_ready = 1'b1;
        step();
        chk("ready_one_cycle_after_release", ready, 1);
        exp_q.delete();
        rdy_prev = ready;
        sent     = 0;
        done_n   = 0;
        done_cyc = -1;
        last_cyc = -1;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            if (frame_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_entry", head(), 11'h7FF);
                end else begin
                    e = exp_q.pop_front();
                    if ((e[10] == 1'b1) || (e[8] == 1'b1))
                        $display("entry sof/eof: head=0x%03h expected=0x%03h", head(), e);
                    chk("stream_entry", head(), e);
                end
            end
            if (rdy_prev && sent < 1024) begin
                valid = 1'b1;
                pixel = 8'(sent);
                exp_q.push_back({(sent == 0), ((sent % 32) == 31), (sent == 1023), 8'(sent)});
                sent++;
                last_cyc = cyc;
            end else begin
                valid = 1'b0;
            end
            rdy_prev = ready;
            step();
        end
        valid = 1'b0;
        chk("stream_beats_sent", sent, 1024);
        chk("stream_queue_drained", exp_q.size(), 0);
        chk("stream_done_pulses", done_n, 1);
        chk("stream_done_timing", done_cyc, last_cyc + 1);
        chk("stream_frame_sum", frame_sum, 16'hFE00);
        chk("stream_frame_count", frame_count, 1);
        chk("stream_overflow", overflow, 0);

        // Back-pressure: FIFO fills to exactly 4, ready drops at count 3
        do_reset();
        out_ready = 1'b0;
        step();
        exp_q.delete();
        rdy_prev = 1'b0;
        pushed   = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            chk($sformatf("bp_ready_count%0d", pushed), ready, (pushed <= 2));
            if (rdy_prev) begin
                valid = 1'b1;
                pixel = 8'hA0 + 8'(pushed);
                exp_q.push_back({(pushed == 0), 1'b0, 1'b0, 8'hA0 + 8'(pushed)});
                pushed++;
            end else begin
                valid = 1'b0;
            end
            rdy_prev = ready;
            step();
        end
        valid = 1'b0;
        $display("backpressure: beats accepted=%0d overflow=%0b", pushed, overflow);
        chk("bp_beats_stored", pushed, 4);
        chk("bp_overflow", overflow, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_drain%0d_valid", k), out_valid, 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
            chk($sformatf("bp_drain%0d_head", k), head(), e);
            step();
        end
        chk("bp_empty_after_drain", out_valid, 0);

        // Mid-frame reset: partial frame discarded, next beat is sof
        do_reset();
        out_ready = 1'b1;
        valid     = 1'b1;
        for (int b = 0; b < 500; b++) begin
            pixel = 8'($urandom_range(0, 255));
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_ready", ready, 0);
        chk("async_rst_head", head(), 0);
        valid = 1'b0;
        step();
        rst_n  = 1'b1;
        valid  = 1'b1;
        pixel  = 8'h01;
        done_n = 0;
        for (int b = 0; b < 1024; b++) begin
            step();
            if (b == 0) chk("post_rst_first_sof", head(), 11'h401);
            if (frame_done) begin
                done_n++;
                chk("post_rst_done_beat", b, 1023);
            end
        end
        valid = 1'b0;
        step();
        $display("post-reset frame: done pulses=%0d sum=0x%04h count=%0d", done_n, frame_sum, frame_count);
        chk("post_rst_done_pulses", done_n, 1);
        chk("post_rst_done_cleared", frame_done, 0);
        chk("post_rst_frame_sum", frame_sum, 16'h0400);
        chk("post_rst_frame_count", frame_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_consumer.md
PIXEL_CONSUMER -- requirements
Module: pixel_consumer

Interface
REQ-001 Parameter IMAGE_SIZE, default 1024, pixels per frame.
REQ-002 Parameter IMAGE_WIDTH, default 32, pixels per line; IMAGE_SIZE SHALL be an integer multiple of it.
REQ-003 Parameter FIFO_DEPTH, default 4, entries in the skid FIFO; power of two, minimum 4.
REQ-004 sensor_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pixel  input  8  upstream pixel data, qualified by valid.
REQ-007 valid  input  1  upstream beat strobe; a beat SHALL be taken on every edge where valid=1, with no ready qualification.
REQ-008 ready  output  1  consumer can absorb further beats; sampled by the producer one cycle before the beat arrives.
REQ-009 out_pixel  output  8  FIFO head pixel.
REQ-010 out_sof / out_eol / out_eof  output  1 each  head pixel is first of frame / last of line / last of frame.
REQ-011 out_valid  output  1  FIFO not empty.
REQ-012 out_ready  input  1  downstream accepts the head entry.
REQ-013 frame_done  output  1  single-cycle pulse when the last pixel of a frame is written.
REQ-014 frame_sum  output  16  modulo-2^16 sum of all pixels of the last completed frame.
REQ-015 frame_count  output  16  completed frames, wraps 0xFFFF->0.
REQ-016 overflow  output  1  sticky error flag, beat dropped.

Function
REQ-017 Producer latency: a beat can arrive on the edge after the one on which ready was sampled high; ready SHALL therefore be 1 only when free entries >= 2, computed combinationally from the registered FIFO count and the run flag.
REQ-018 Run flag: 0 in reset, set on the first edge after rst_n rises; ready SHALL be 0 while the run flag is 0.
REQ-019 FIFO entry SHALL be 11 bits: {sof, eol, eof, pixel}, written in arrival order.
REQ-020 Pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_pixel and the flags SHALL show the head entry with zero added latency and SHALL hold while out_ready=0.
REQ-021 Push with FIFO full SHALL succeed if a pop occurs on the same edge; otherwise the beat SHALL be dropped, overflow set to 1, and pixel counters still advanced.
REQ-022 Simultaneous push and pop at any occupancy SHALL leave count unchanged.
REQ-023 Column counter col (0..IMAGE_WIDTH-1) and pixel index idx (0..IMAGE_SIZE-1) SHALL advance by one per beat and wrap to 0 after their maximum.
REQ-024 Flags: sof = (idx==0); eol = (col==IMAGE_WIDTH-1); eof = (idx==IMAGE_SIZE-1).
REQ-025 Running sum: on sof beat load pixel zero-extended, else add modulo 2^16.
REQ-026 On eof beat: frame_sum <= running sum including this pixel; frame_done = 1 for exactly one cycle; frame_count += 1.
REQ-027 Beats with valid=0 SHALL change no counter, sum or FIFO state.

Reset
REQ-028 rst_n low SHALL immediately force: ready 0, out_valid 0, FIFO count 0, col 0, idx 0, running sum 0, frame_sum 0, frame_count 0, frame_done 0, overflow 0, run flag 0.
REQ-029 out_pixel and out_sof/eol/eof SHALL read 0 during reset.
REQ-030 Reset mid-frame SHALL discard partial frame and FIFO contents; the next beat after release SHALL be treated as sof.
REQ-031 overflow SHALL clear only by reset.

Verification
REQ-032 Reset release, out_ready=1, producer streaming 0x00..0xFF repeating -> ready=1 one cycle after release; out_pixel sequence equals input; no overflow.
REQ-033 Full frame of 1024 pixels with value idx[7:0] -> frame_done pulses once on the 1024th beat; frame_sum=0xFE00; frame_count=1; out_eol on every 32nd entry; out_sof on entry 0; out_eof on entry 1023.
REQ-034 out_ready=0 held with compliant producer -> FIFO fills to exactly FIFO_DEPTH (4), ready drops at count 3, no beat lost, overflow stays 0; release out_ready -> all 4 entries drain in order.
REQ-035 Bench forces valid=1 for 6 edges with out_ready=0 -> 4 entries stored, overflow=1, idx=6; an extra beat pushed with FIFO full and out_ready=1 on the same edge is accepted.
REQ-036 Reset asserted after 500 beats, then 1024 beats of 0x01 -> frame_done after 1024th post-reset beat, frame_sum=0x0400, frame_count=1.
